input_buffer_pp: RTL and testbench

Ping-pong (double-banked) parallel-in, serial-out capture buffer with downstream backpressure and a per-run channel mask. The block captures one run of LENGTH samples from NSINK parallel buses into one bank while the other bank is streamed out. Output is channel by channel as Avalon-ST-style packets, one per enabled channel. It sits between the multi-channel front end and the serial processing chain, in the sink_clk domain.

---
 rtl/input_buffer_pp.sv | 360 ++++++++++++++++++++++++++++++++++++
 tb/tb_input_buffer_pp.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/input_buffer_pp.sv
// input_buffer_pp: ping-pong parallel-in / serial-out capture buffer.
// One bank captures a run of LENGTH samples from NSINK buses while the other
// bank streams out channel by channel as sop/eop framed packets with backpressure.

module input_buffer_pp #(
    parameter int unsigned NSINK  = 4,
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned LENGTH = 256,
    localparam int unsigned AWIDTH = $clog2(LENGTH),
    localparam int unsigned BWIDTH = (NSINK > 1) ? $clog2(NSINK) : 1
) (
    input  logic              sink_clk,
    input  logic              reset,
    input  logic              sink_start,
    input  logic [NSINK-1:0]  sink_mask,
    input  logic [WIDTH-1:0]  sink_data [0:NSINK-1],
    output logic              sink_ready,
    output logic              sink_overflow,
    input  logic              source_ready,
    output logic              source_valid,
    output logic              source_sop,
    output logic              source_eop,
    output logic [BWIDTH-1:0] source_channel,
    output logic [WIDTH-1:0]  source_data
);

    localparam int unsigned       MemDepth = 2 * (2 ** AWIDTH);
    localparam logic [AWIDTH-1:0] LastAddr = AWIDTH'(LENGTH - 1);

    typedef enum logic {WrIdle, WrCapture} wr_state_e;
    typedef enum logic {RdIdle, RdRead} rd_state_e;

    // One beat as it sits in the output skid buffer.
    typedef struct packed {
        logic [WIDTH-1:0]  data;
        logic              sop;
        logic              eop;
        logic [BWIDTH-1:0] ch;
        logic              last;  // final beat of the bank; frees it when accepted
        logic              bank;
    } beat_t;

    // Lowest set bit of a channel mask.
    function automatic logic [BWIDTH-1:0] lowest_ch(input logic [NSINK-1:0] m);
        lowest_ch = '0;
        for (int i = int'(NSINK) - 1; i >= 0; i--) begin
            if (m[i]) lowest_ch = BWIDTH'(i);
        end
    endfunction

    // Mask bits strictly above channel ch.
    function automatic logic [NSINK-1:0] mask_above(input logic [NSINK-1:0] m,
                                                    input logic [BWIDTH-1:0] ch);
        mask_above = '0;
        for (int i = 0; i < int'(NSINK); i++) begin
            if (i > int'(ch)) mask_above[i] = m[i];
        end
    endfunction

    // ------------------------------------------------------------------
    // Write side
    // ------------------------------------------------------------------
    wr_state_e         wr_state_q, wr_state_d;
    logic              wr_bank_q, wr_bank_d;
    logic [AWIDTH-1:0] wr_addr_q, wr_addr_d;
    logic              ready_q, overflow_q;
    logic              accept;
    logic              free_bank;
    logic              capture_done;
    logic              mem_we;
    logic              mem_wbank;
    logic [AWIDTH-1:0] mem_waddr;

    // Bank bookkeeping: used = not free, full = captured and waiting for the reader.
    logic [1:0]        bank_used_q, bank_used_d;
    logic [1:0]        bank_full_q, bank_full_d;
    logic [NSINK-1:0]  bank_mask_q [2];
    logic [NSINK-1:0]  bank_mask_d [2];
    logic              older_q, older_d;

    assign accept    = sink_start && ready_q;
    assign free_bank = bank_used_q[0] ? 1'b1 : 1'b0;

    // Write FSM next state and RAM write port control.
    always_comb begin
        wr_state_d   = wr_state_q;
        wr_bank_d    = wr_bank_q;
        wr_addr_d    = wr_addr_q;
        mem_we       = 1'b0;
        mem_wbank    = wr_bank_q;
        mem_waddr    = wr_addr_q;
        capture_done = 1'b0;
        case (wr_state_q)
            WrIdle: begin
                if (accept) begin
                    mem_we     = 1'b1;
                    mem_wbank  = free_bank;
                    mem_waddr  = '0;
                    wr_bank_d  = free_bank;
                    wr_addr_d  = AWIDTH'(1);
                    wr_state_d = WrCapture;
                end
            end
            WrCapture: begin
                mem_we = 1'b1;
                if (wr_addr_q == LastAddr) begin
                    capture_done = 1'b1;
                    wr_state_d   = WrIdle;
                end else begin
                    wr_addr_d = wr_addr_q + AWIDTH'(1);
                end
            end
            default: wr_state_d = WrIdle;
        endcase
    end

    // Write FSM state register.
    always_ff @(posedge sink_clk) begin
        if (reset) begin
            wr_state_q <= WrIdle;
            wr_bank_q  <= 1'b0;
            wr_addr_q  <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            wr_bank_q  <= wr_bank_d;
            wr_addr_q  <= wr_addr_d;
        end
    end

    // Registered sink handshake; a freed bank shows up in sink_ready one cycle late.
    always_ff @(posedge sink_clk) begin
        if (reset) begin
            ready_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            ready_q    <= (wr_state_d == WrIdle) && !(&bank_used_q);
            overflow_q <= sink_start && !ready_q;
        end
    end

    assign sink_ready    = ready_q;
    assign sink_overflow = overflow_q;

    // ------------------------------------------------------------------
    // Read side
    // ------------------------------------------------------------------
    rd_state_e         rd_state_q, rd_state_d;
    logic              rd_bank_q, rd_bank_d;
    logic [BWIDTH-1:0] rd_ch_q, rd_ch_d;
    logic [AWIDTH-1:0] rd_addr_q, rd_addr_d;
    logic              rd_pick;
    logic [BWIDTH-1:0] first_ch;
    logic              rd_start;
    logic              issue;
    logic              can_issue;
    logic              iss_bank;
    logic [BWIDTH-1:0] iss_ch;
    logic [AWIDTH-1:0] iss_addr;
    logic              iss_last;
    logic [NSINK-1:0]  above;

    // Read pipeline stage 1 (RAM output) and skid buffer.
    logic              p1_valid_q, p1_sop_q, p1_eop_q, p1_last_q, p1_bank_q;
    logic [BWIDTH-1:0] p1_ch_q;
    logic [WIDTH-1:0]  ram_rdata [NSINK];
    beat_t             ent_q [2];
    beat_t             push_beat;
    beat_t             head;
    logic              wr_ptr_q, rd_ptr_q;
    logic [1:0]        count_q, count_d;
    logic              pop;

    // Oldest full bank; with only one full bank it is simply that one.
    assign rd_pick   = (&bank_full_q) ? older_q : bank_full_q[1];
    assign first_ch  = lowest_ch(bank_mask_q[rd_pick]);
    assign pop       = (count_q != 2'd0) && source_ready;
    // Beats in the buffer plus in flight must never exceed the two skid entries.
    assign can_issue = (int'(count_q) + int'(p1_valid_q) - int'(pop)) < 2;

    // Read FSM: walks enabled channels and addresses, one RAM read per issue.
    always_comb begin
        rd_state_d = rd_state_q;
        rd_bank_d  = rd_bank_q;
        rd_ch_d    = rd_ch_q;
        rd_addr_d  = rd_addr_q;
        rd_start   = 1'b0;
        issue      = 1'b0;
        iss_bank   = rd_bank_q;
        iss_ch     = rd_ch_q;
        iss_addr   = rd_addr_q;
        iss_last   = 1'b0;
        above      = '0;
        case (rd_state_q)
            RdIdle: begin
                // Start issues in the same cycle so a new bank costs no bubble.
                if (|bank_full_q) begin
                    rd_start   = 1'b1;
                    rd_bank_d  = rd_pick;
                    rd_ch_d    = first_ch;
                    rd_addr_d  = '0;
                    iss_bank   = rd_pick;
                    iss_ch     = first_ch;
                    iss_addr   = '0;
                    rd_state_d = RdRead;
                end
            end
            RdRead: ;
            default: rd_state_d = RdIdle;
        endcase
        if ((rd_state_q == RdRead || rd_start) && can_issue) begin
            issue = 1'b1;
            if (iss_addr == LastAddr) begin
                above = mask_above(bank_mask_q[iss_bank], iss_ch);
                if (|above) begin
                    rd_ch_d   = lowest_ch(above);
                    rd_addr_d = '0;
                end else begin
                    iss_last   = 1'b1;
                    rd_state_d = RdIdle;
                end
            end else begin
                rd_addr_d = iss_addr + AWIDTH'(1);
            end
        end
    end

    // Read FSM state register.
    always_ff @(posedge sink_clk) begin
        if (reset) begin
            rd_state_q <= RdIdle;
            rd_bank_q  <= 1'b0;
            rd_ch_q    <= '0;
            rd_addr_q  <= '0;
        end else begin
            rd_state_q <= rd_state_d;
            rd_bank_q  <= rd_bank_d;
            rd_ch_q    <= rd_ch_d;
            rd_addr_q  <= rd_addr_d;
        end
    end

    // Bank state updates from capture start/end, reader start and final beat accept.
    always_comb begin
        bank_used_d = bank_used_q;
        bank_full_d = bank_full_q;
        bank_mask_d = bank_mask_q;
        older_d     = older_q;
        if (accept) begin
            bank_used_d[free_bank] = 1'b1;
            bank_mask_d[free_bank] = sink_mask;
        end
        if (capture_done) begin
            if (|bank_mask_q[wr_bank_q]) begin
                bank_full_d[wr_bank_q] = 1'b1;
                older_d = bank_full_q[~wr_bank_q] ? ~wr_bank_q : wr_bank_q;
            end else begin
                // Nothing enabled: nothing to read, release immediately.
                bank_used_d[wr_bank_q] = 1'b0;
            end
        end
        if (rd_start) bank_full_d[rd_pick] = 1'b0;
        if (pop && head.last) bank_used_d[head.bank] = 1'b0;
    end

    // Bank state register.
    always_ff @(posedge sink_clk) begin
        if (reset) begin
            bank_used_q    <= '0;
            bank_full_q    <= '0;
            bank_mask_q[0] <= '0;
            bank_mask_q[1] <= '0;
            older_q        <= 1'b0;
        end else begin
            bank_used_q <= bank_used_d;
            bank_full_q <= bank_full_d;
            bank_mask_q <= bank_mask_d;
            older_q     <= older_d;
        end
    end

    // Per-channel dual-port RAM holding both banks: {bank, addr} addressing.
    for (genvar g = 0; g < int'(NSINK); g++) begin : g_ram
        logic [WIDTH-1:0] mem [0:MemDepth-1];
        logic [WIDTH-1:0] rdata_q;

        // Synchronous write of the capture sample and registered read for the reader.
        always_ff @(posedge sink_clk) begin
            if (mem_we) mem[{mem_wbank, mem_waddr}] <= sink_data[g];
            if (issue) rdata_q <= mem[{iss_bank, iss_addr}];
        end

        assign ram_rdata[g] = rdata_q;
    end

    // Framing sideband travelling alongside the RAM read.
    always_ff @(posedge sink_clk) begin
        if (reset) begin
            p1_valid_q <= 1'b0;
            p1_sop_q   <= 1'b0;
            p1_eop_q   <= 1'b0;
            p1_last_q  <= 1'b0;
            p1_bank_q  <= 1'b0;
            p1_ch_q    <= '0;
        end else begin
            p1_valid_q <= issue;
            p1_sop_q   <= (iss_addr == '0);
            p1_eop_q   <= (iss_addr == LastAddr);
            p1_last_q  <= iss_last;
            p1_bank_q  <= iss_bank;
            p1_ch_q    <= iss_ch;
        end
    end

    // Assemble the beat leaving the RAM stage.
    always_comb begin
        push_beat      = '0;
        push_beat.data = ram_rdata[p1_ch_q];
        push_beat.sop  = p1_sop_q;
        push_beat.eop  = p1_eop_q;
        push_beat.ch   = p1_ch_q;
        push_beat.last = p1_last_q;
        push_beat.bank = p1_bank_q;
    end

    // Skid buffer occupancy.
    always_comb begin
        count_d = count_q;
        case ({p1_valid_q, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Two-entry skid buffer; the head entry drives the source outputs.
    always_ff @(posedge sink_clk) begin
        if (reset) begin
            ent_q[0] <= '0;
            ent_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (p1_valid_q) begin
                ent_q[wr_ptr_q] <= push_beat;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_d;
        end
    end

    assign head           = ent_q[rd_ptr_q];
    assign source_valid   = (count_q != 2'd0);
    assign source_data    = head.data;
    assign source_sop     = head.sop;
    assign source_eop     = head.eop;
    assign source_channel = head.ch;

endmodule

// File: tb/tb_input_buffer_pp.sv
// Directed bench for input_buffer_pp (NSINK=4, WIDTH=16, LENGTH=8).
// Expected beats are generated from the sample pattern base + 16*ch + n.

module tb_input_buffer_pp;

    localparam int NSINK  = 4;
    localparam int WIDTH  = 16;
    localparam int LENGTH = 8;

    logic             sink_clk = 1'b0;
    logic             reset = 1'b1;
    logic             sink_start = 1'b0;
    logic [3:0]       sink_mask = 4'h0;
    logic [15:0]      sink_data [0:3];
    logic             sink_ready;
    logic             sink_overflow;
    logic             source_ready = 1'b1;
    logic             source_valid;
    logic             source_sop;
    logic             source_eop;
    logic [1:0]       source_channel;
    logic [15:0]      source_data;

    typedef struct packed {
        logic [1:0]  ch;
        logic [15:0] data;
        logic        sop;
        logic        eop;
    } beat_t;

    beat_t exp_q [$];
    int    n_checks = 0;
    int    n_fail = 0;
    int    rx_count = 0;
    int    ovf_count = 0;
    int    rand_mode = 0;
    logic  held = 1'b0;
    beat_t held_beat;

    always #5 sink_clk = ~sink_clk;

    input_buffer_pp #(
        .NSINK  (NSINK),
        .WIDTH  (WIDTH),
        .LENGTH (LENGTH)
    ) dut (
        .sink_clk       (sink_clk),
        .reset          (reset),
        .sink_start     (sink_start),
        .sink_mask      (sink_mask),
        .sink_data      (sink_data),
        .sink_ready     (sink_ready),
        .sink_overflow  (sink_overflow),
        .source_ready   (source_ready),
        .source_valid   (source_valid),
        .source_sop     (source_sop),
        .source_eop     (source_eop),
        .source_channel (source_channel),
        .source_data    (source_data)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Downstream ready: always 1, or a coin flip per cycle in random mode.
    always begin
        @(posedge sink_clk);
        #1;
        source_ready = (rand_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Output monitor: scoreboard compare, stall stability, overflow count.
    always @(negedge sink_clk) begin
        beat_t cur;
        beat_t e;
        cur = '{ch: source_channel, data: source_data, sop: source_sop, eop: source_eop};
        if (reset) begin
            held = 1'b0;
        end else begin
            if (held) begin
                check_eq("hold_valid", source_valid, 1);
                check_eq("hold_beat", cur, held_beat);
            end
            if (sink_overflow) ovf_count++;
            if (source_valid && source_ready) begin
                rx_count++;
                if (exp_q.size() == 0) begin
                    check_eq("extra_beat", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    check_eq($sformatf("beat%0d", rx_count), cur, e);
                end
            end
            held      = source_valid && !source_ready;
            held_beat = cur;
        end
    end

    task automatic push_run(input logic [15:0] base, input logic [3:0] mask);
        for (int c = 0; c < NSINK; c++) begin
            if (mask[c]) begin
                for (int n = 0; n < LENGTH; n++) begin
                    beat_t b;
                    b.ch   = 2'(c);
                    b.data = base + 16'(16 * c + n);
                    b.sop  = (n == 0);
                    b.eop  = (n == LENGTH - 1);
                    exp_q.push_back(b);
                end
            end
        end
    endtask

    // Waits for sink_ready, then drives one run; returns in cycle LENGTH after accept.
    task automatic capture(input logic [15:0] base, input logic [3:0] mask,
                           input int restart_at, output int rx_at_accept);
        int w = 0;
        while (!sink_ready && w < 500) begin
            @(posedge sink_clk);
            #1;
            w++;
        end
        check_eq("cap_ready", sink_ready, 1);
        rx_at_accept = rx_count;
        for (int n = 0; n < LENGTH; n++) begin
            sink_start = (n == 0) || (n == restart_at);
            sink_mask  = (n == restart_at) ? 4'b0001 : mask;
            for (int i = 0; i < NSINK; i++) sink_data[i] = base + 16'(16 * i + n);
            @(posedge sink_clk);
            #1;
        end
        sink_start = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int w = 0;
        while ((exp_q.size() != 0 || source_valid) && w < budget) begin
            @(posedge sink_clk);
            #1;
            w++;
        end
        check_eq("drain_left", exp_q.size(), 0);
        repeat (3) @(posedge sink_clk);
        #1;
    endtask

    initial begin
        int rx0;
        int ovf0;
        int acc;
        int w;
        for (int i = 0; i < NSINK; i++) sink_data[i] = 16'h0;

        // Reset values
        repeat (2) @(posedge sink_clk);
        #1;
        reset = 1'b0;
        check_eq("rst_valid", source_valid, 0);
        check_eq("rst_sop", source_sop, 0);
        check_eq("rst_eop", source_eop, 0);
        check_eq("rst_channel", source_channel, 0);
        check_eq("rst_data", source_data, 0);
        check_eq("rst_ready", sink_ready, 1);
        check_eq("rst_overflow", sink_overflow, 0);

        // 1: full mask, latency of first valid
        push_run(16'h0000, 4'hF);
        capture(16'h0000, 4'hF, -1, acc);
        check_eq("t1_ready_c8", sink_ready, 1);
        check_eq("t1_valid_c8", source_valid, 0);
        @(posedge sink_clk);
        #1;
        check_eq("t1_valid_c9", source_valid, 0);
        @(posedge sink_clk);
        #1;
        check_eq("t1_valid_c10", source_valid, 1);
        check_eq("t1_sop_c10", source_sop, 1);
        wait_drain(200);

        // 2: partial mask, then empty mask run
        push_run(16'h0020, 4'b0101);
        capture(16'h0020, 4'b0101, -1, acc);
        capture(16'h0090, 4'b0000, -1, acc);
        check_eq("t2_ready_f1", sink_ready, 0);
        @(posedge sink_clk);
        #1;
        check_eq("t2_ready_f2", sink_ready, 1);
        wait_drain(200);

        // 3: A, B back to back, C dropped then accepted after A
        rx0  = rx_count;
        ovf0 = ovf_count;
        push_run(16'h0100, 4'hF);
        capture(16'h0100, 4'hF, -1, acc);
        push_run(16'h0200, 4'b1010);
        capture(16'h0200, 4'b1010, -1, acc);
        check_eq("t3_ready_full", sink_ready, 0);
        sink_start = 1'b1;
        sink_mask  = 4'hF;
        @(posedge sink_clk);
        #1;
        sink_start = 1'b0;
        check_eq("t3_ready_drop", sink_ready, 0);
        @(posedge sink_clk);
        #1;
        check_eq("t3_overflow_cnt", ovf_count - ovf0, 1);
        push_run(16'h0300, 4'hF);
        capture(16'h0300, 4'hF, -1, acc);
        check_eq("t3_c_after_a", ((acc - rx0) >= 32) && ((acc - rx0) < 48), 1);
        wait_drain(400);

        // 4: random backpressure over two runs
        rand_mode = 1;
        push_run(16'h0400, 4'hF);
        capture(16'h0400, 4'hF, -1, acc);
        push_run(16'h0480, 4'b0110);
        capture(16'h0480, 4'b0110, -1, acc);
        wait_drain(600);
        rand_mode = 0;
        repeat (2) @(posedge sink_clk);
        #1;

        // 5: repeated start mid-capture
        ovf0 = ovf_count;
        push_run(16'h0500, 4'hF);
        capture(16'h0500, 4'hF, 3, acc);
        check_eq("t5_overflow_cnt", ovf_count - ovf0, 1);
        wait_drain(200);

        // 6: reset after five beats, then a fresh run
        rx0 = rx_count;
        push_run(16'h0600, 4'hF);
        capture(16'h0600, 4'hF, -1, acc);
        w = 0;
        while ((rx_count - rx0) < 5 && w < 100) begin
            @(posedge sink_clk);
            #1;
            w++;
        end
        check_eq("t6_beats_before_reset", rx_count - rx0, 5);
        reset = 1'b1;
        @(posedge sink_clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        check_eq("t6_valid", source_valid, 0);
        check_eq("t6_sop", source_sop, 0);
        check_eq("t6_eop", source_eop, 0);
        check_eq("t6_channel", source_channel, 0);
        check_eq("t6_data", source_data, 0);
        check_eq("t6_ready", sink_ready, 1);
        push_run(16'h0700, 4'b1001);
        capture(16'h0700, 4'b1001, -1, acc);
        wait_drain(200);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
